// File: rtl/rvv_pkg.sv
// Shared RVV types: vtype layout, element/LMUL/LUT encodings, instruction view
// and the config-unit FSM state.
package rvv_pkg;

    localparam int         RISCV_MAX_VLEN = 65536;
    localparam logic [6:0] OPC_VECTOR     = 7'h57;

    typedef enum logic [2:0] {
        EW8 = 3'd0, EW16, EW32, EW64, EW128, EW256, EW512, EW1024
    } vew_e;

    typedef enum logic [2:0] {
        LMUL_1 = 3'd0, LMUL_2, LMUL_4, LMUL_8,
        LMUL_RSVD, LMUL_1_8, LMUL_1_4, LMUL_1_2
    } vlmul_e;

    typedef enum logic [2:0] {
        CB_NONE = 3'd0, CB16, CB32, CB64, CB128, CB256, CB_RSVD6, CB_RSVD7
    } vlut_e;

    typedef enum logic [2:0] {
        OPIVV = 3'd0, OPFVV, OPMVV, OPIVI, OPIVX, OPFVF, OPMVX, OPCFG
    } opcodev_func3_e;

    typedef struct packed {
        logic   vill;
        vlut_e  vlut;
        logic   vma;
        logic   vta;
        vew_e   vsew;
        vlmul_e vlmul;
    } vtype_t;

    // Generic OP-V view; zimm covers bits [31:20] of every config form.
    typedef struct packed {
        logic [11:0]    zimm;
        logic [4:0]     rs1;
        opcodev_func3_e func3;
        logic [4:0]     rd;
        logic [6:0]     opcode;
    } vcfg_instr_t;

    typedef enum logic [1:0] {
        VCFG_IDLE = 2'd0, VCFG_CALC, VCFG_RESP
    } vcfg_state_e;

    localparam vtype_t VTYPE_VILL = vtype_t'(12'h800);

    function automatic vtype_t vtype_from_bits(input logic [10:0] bits);
        return vtype_t'({1'b0, bits});
    endfunction

endpackage

// File: rtl/vcfg_if.sv
// Request/response and architectural-state bundle of the vector config unit.
interface vcfg_if;
    import rvv_pkg::*;

    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_instr_i;
    logic [63:0] req_rs1_i;
    logic [63:0] req_rs2_i;
    logic        pipe_idle_i;
    logic        flush_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [63:0] resp_result_o;
    logic        resp_illegal_o;
    logic [63:0] vl_o;
    vtype_t      vtype_o;

    modport master (
        output req_valid_i, req_instr_i, req_rs1_i, req_rs2_i,
               pipe_idle_i, flush_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_result_o, resp_illegal_o,
               vl_o, vtype_o
    );

    modport slave (
        input  req_valid_i, req_instr_i, req_rs1_i, req_rs2_i,
               pipe_idle_i, flush_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_result_o, resp_illegal_o,
               vl_o, vtype_o
    );

endinterface

// File: rtl/vcfg_unit_vlmax.sv
// VLMAX for a requested SEW/LMUL pair; pure combinational.
module vcfg_vlmax
    import rvv_pkg::*;
#(
    parameter int VLEN = 4096
) (
    input  vew_e        vsew,
    input  vlmul_e      vlmul,
    output logic [63:0] vlmax
);

    logic [63:0] base;

    always_comb begin
        base = 64'(VLEN) >> (4'd3 + {1'b0, vsew});
        if (vlmul[2]) vlmax = base >> (4'd8 - {1'b0, vlmul});
        else          vlmax = base << vlmul[1:0];
    end

endmodule

// File: rtl/vcfg_unit.sv
// vsetvl/vsetvli/vsetivli execution: decode, legality, vl/vtype update and a
// single-outstanding request/response handshake gated on pipeline drain.
module vcfg_unit
    import rvv_pkg::*;
#(
    parameter int VLEN = 4096,
    parameter int ELEN = 64
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    vcfg_if.slave  bus
);

    vcfg_state_e state_q, state_d;
    logic [31:0] instr_q;
    logic [63:0] rs1_q, rs2_q, vl_q, result_q;
    vtype_t      vtype_q;
    logic        illegal_q;

    vcfg_instr_t ins;
    logic        is_cfg, is_vli, is_ivli, is_vl, illegal, frac, vill;
    logic [10:0] req_bits;
    vtype_t      req_vtype, new_vtype;
    logic [10:0] sew_bits;
    logic [31:0] elen_frac;
    logic [63:0] vlmax, avl, new_vl;

    assign ins = vcfg_instr_t'(instr_q);

    vcfg_vlmax #(.VLEN(VLEN)) u_vlmax (
        .vsew  (req_vtype.vsew),
        .vlmul (req_vtype.vlmul),
        .vlmax (vlmax)
    );

    always_comb begin
        is_cfg   = (ins.opcode == OPC_VECTOR) && (ins.func3 == OPCFG);
        is_vli   = is_cfg && !instr_q[31];
        is_ivli  = is_cfg && (instr_q[31:30] == 2'b11);
        is_vl    = is_cfg && (instr_q[31:25] == 7'b1000000);
        illegal  = !(is_vli || is_ivli || is_vl);
        req_bits = instr_q[30:20];
        if (is_ivli)    req_bits = {1'b0, instr_q[29:20]};
        else if (is_vl) req_bits = rs2_q[10:0];
        req_vtype = vtype_from_bits(req_bits);
    end

    // Fractional LMUL shrinks the widest legal SEW to ELEN*LMUL.
    always_comb begin
        sew_bits  = 11'd8 << req_vtype.vsew;
        frac      = req_vtype.vlmul[2] && (req_vtype.vlmul != LMUL_RSVD);
        elen_frac = 32'(ELEN) >> (4'd8 - {1'b0, req_vtype.vlmul});
        vill = (req_vtype.vlmul == LMUL_RSVD)
            || (32'(sew_bits) > 32'(ELEN))
            || (req_vtype.vlut > CB256)
            || (frac && (32'(sew_bits) > elen_frac))
            || (is_vl && (|rs2_q[63:11]));
    end

    always_comb begin
        if (is_ivli)              avl = 64'(ins.rs1);
        else if (ins.rs1 != 5'd0) avl = rs1_q;
        else if (ins.rd != 5'd0)  avl = vlmax;
        else                      avl = vl_q;
        new_vl    = vill ? 64'd0 : ((avl < vlmax) ? avl : vlmax);
        new_vtype = vill ? VTYPE_VILL : req_vtype;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= VCFG_IDLE;
        else         state_q <= state_d;
    end

    // Flush outranks drain; illegal words never wait for the pipeline.
    always_comb begin
        state_d = state_q;
        case (state_q)
            VCFG_IDLE: if (bus.req_valid_i) state_d = VCFG_CALC;
            VCFG_CALC: begin
                if (bus.flush_i)                       state_d = VCFG_IDLE;
                else if (illegal || bus.pipe_idle_i)   state_d = VCFG_RESP;
            end
            VCFG_RESP: if (bus.resp_ready_i) state_d = VCFG_IDLE;
            default:   state_d = VCFG_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready_o  = (state_q == VCFG_IDLE);
        bus.resp_valid_o = (state_q == VCFG_RESP);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_q   <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            vl_q      <= '0;
            vtype_q   <= VTYPE_VILL;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (state_q == VCFG_IDLE && bus.req_valid_i) begin
                instr_q <= bus.req_instr_i;
                rs1_q   <= bus.req_rs1_i;
                rs2_q   <= bus.req_rs2_i;
            end
            if (state_q == VCFG_CALC && !bus.flush_i) begin
                if (illegal) begin
                    result_q  <= '0;
                    illegal_q <= 1'b1;
                end else if (bus.pipe_idle_i) begin
                    vl_q      <= new_vl;
                    vtype_q   <= new_vtype;
                    result_q  <= new_vl;
                    illegal_q <= 1'b0;
                end
            end
        end
    end

    assign bus.resp_result_o  = result_q;
    assign bus.resp_illegal_o = illegal_q;
    assign bus.vl_o           = vl_q;
    assign bus.vtype_o        = vtype_q;

endmodule

// File: tb/tb_vcfg_unit.sv
// Directed checks of vcfg_unit: decode forms, vill cases, drain/flush timing, reset.
module tb_vcfg_unit;
    import rvv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    vcfg_if bus ();

    vcfg_unit #(.VLEN(4096), .ELEN(64)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_vli(input logic [10:0] z, input logic [4:0] s1, input logic [4:0] d);
        return {1'b0, z, s1, 3'b111, d, 7'h57};
    endfunction

    function automatic logic [31:0] mk_ivli(input logic [9:0] z, input logic [4:0] u, input logic [4:0] d);
        return {2'b11, z, u, 3'b111, d, 7'h57};
    endfunction

    function automatic logic [31:0] mk_vl(input logic [4:0] s2, input logic [4:0] s1, input logic [4:0] d);
        return {7'b1000000, s2, s1, 3'b111, d, 7'h57};
    endfunction

    task automatic send(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        chk("req_ready", 64'(bus.req_ready_o), 64'd1);
        bus.req_valid_i = 1'b1;
        bus.req_instr_i = ins;
        bus.req_rs1_i   = a;
        bus.req_rs2_i   = b;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
    endtask

    task automatic get_resp(input string tag, input logic [63:0] exp_res, input logic exp_ill);
        int n = 0;
        while (bus.resp_valid_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 64'(bus.resp_valid_o), 64'd1);
        chk({tag, "_result"}, bus.resp_result_o, exp_res);
        chk({tag, "_illegal"}, 64'(bus.resp_illegal_o), 64'(exp_ill));
        bus.resp_ready_i = 1'b1;
        @(negedge clk);
        bus.resp_ready_i = 1'b0;
    endtask

    task automatic arch(input string tag, input logic [63:0] exp_vl, input logic [11:0] exp_vt);
        chk({tag, "_vl"}, bus.vl_o, exp_vl);
        chk({tag, "_vtype"}, 64'(bus.vtype_o), 64'(exp_vt));
    endtask

    task automatic cfg(input string tag, input logic [31:0] ins, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp_res, input logic exp_ill,
                       input logic [63:0] exp_vl, input logic [11:0] exp_vt);
        send(ins, a, b);
        get_resp(tag, exp_res, exp_ill);
        arch(tag, exp_vl, exp_vt);
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.req_valid_i  = 1'b0;
        bus.req_instr_i  = '0;
        bus.req_rs1_i    = '0;
        bus.req_rs2_i    = '0;
        bus.pipe_idle_i  = 1'b1;
        bus.flush_i      = 1'b0;
        bus.resp_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        arch("rst", 64'd0, 12'h800);
        chk("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
        chk("rst_result", bus.resp_result_o, 64'd0);
        chk("rst_illegal", 64'(bus.resp_illegal_o), 64'd0);
        chk("rst_ready", 64'(bus.req_ready_o), 64'd1);
        rst_n = 1'b1;

        // e32,m1, AVL 100; also pins the two-cycle response latency
        send(mk_vli(11'h010, 5'd6, 5'd5), 64'd100, 64'd0);
        chk("lat_calc", 64'(bus.resp_valid_o), 64'd0);
        @(negedge clk);
        chk("lat_resp", 64'(bus.resp_valid_o), 64'd1);
        get_resp("e32m1", 64'd100, 1'b0);
        arch("e32m1", 64'd100, 12'h010);

        cfg("e8m8_x0", mk_vli(11'h003, 5'd0, 5'd1), 64'd0, 64'd0, 64'd4096, 1'b0, 64'd4096, 12'h003);
        cfg("keep_vl", mk_vli(11'h010, 5'd0, 5'd0), 64'd0, 64'd0, 64'd128, 1'b0, 64'd128, 12'h010);
        cfg("avl_max", mk_vli(11'h01B, 5'd6, 5'd5), 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,
            64'd512, 1'b0, 64'd512, 12'h01B);
        cfg("ivli_vill", mk_ivli(10'h01D, 5'd31, 5'd5), 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 12'h800);
        cfg("ivli", mk_ivli(10'h3C0, 5'd31, 5'd5), 64'd0, 64'd0, 64'd31, 1'b0, 64'd31, 12'h3C0);
        cfg("vl_cb256", mk_vl(5'd7, 5'd6, 5'd5), 64'd10, 64'h500, 64'd10, 1'b0, 64'd10, 12'h500);
        cfg("vl_cb_rsvd", mk_vl(5'd7, 5'd6, 5'd5), 64'd10, 64'h600, 64'd0, 1'b0, 64'd0, 12'h800);
        cfg("mf2", mk_vli(11'h007, 5'd6, 5'd5), 64'd1000, 64'd0, 64'd256, 1'b0, 64'd256, 12'h007);
        cfg("vl_rs2_hi", mk_vl(5'd7, 5'd6, 5'd5), 64'd10, 64'h800, 64'd0, 1'b0, 64'd0, 12'h800);
        cfg("e32mf2", mk_vli(11'h017, 5'd0, 5'd1), 64'd0, 64'd0, 64'd64, 1'b0, 64'd64, 12'h017);
        cfg("bad_cfg", {7'b1000001, 5'd7, 5'd6, 3'b111, 5'd5, 7'h57}, 64'd10, 64'd0,
            64'd0, 1'b1, 64'd64, 12'h017);

        // held off by an undrained pipeline, then flush ignored in RESP
        bus.pipe_idle_i = 1'b0;
        send(mk_vli(11'h010, 5'd6, 5'd5), 64'd100, 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 64'(bus.resp_valid_o), 64'd0);
            chk("stall_vl", bus.vl_o, 64'd64);
        end
        bus.pipe_idle_i = 1'b1;
        @(negedge clk);
        chk("drain_valid", 64'(bus.resp_valid_o), 64'd1);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        get_resp("resp_flush", 64'd100, 1'b0);
        arch("resp_flush", 64'd100, 12'h010);

        // flush while waiting for drain
        bus.pipe_idle_i = 1'b0;
        send(mk_vli(11'h003, 5'd6, 5'd5), 64'd200, 64'd0);
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        chk("flush_ready", 64'(bus.req_ready_o), 64'd1);
        repeat (3) @(negedge clk);
        chk("flush_no_resp", 64'(bus.resp_valid_o), 64'd0);
        arch("flush", 64'd100, 12'h010);

        // flush beats pipe_idle in CALC; flush during the IDLE handshake is ignored
        bus.pipe_idle_i = 1'b1;
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_instr_i = mk_vli(11'h003, 5'd6, 5'd5);
        bus.req_rs1_i   = 64'd300;
        bus.flush_i     = 1'b1;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        chk("prio_in_calc", 64'(bus.req_ready_o), 64'd0);
        @(negedge clk);
        bus.flush_i = 1'b0;
        chk("prio_ready", 64'(bus.req_ready_o), 64'd1);
        chk("prio_no_resp", 64'(bus.resp_valid_o), 64'd0);
        arch("prio", 64'd100, 12'h010);

        // non-config word skips the drain wait; reset in RESP discards it
        bus.pipe_idle_i = 1'b0;
        send(32'h0000_0013, 64'd0, 64'd0);
        @(negedge clk);
        chk("ill_valid", 64'(bus.resp_valid_o), 64'd1);
        chk("ill_flag", 64'(bus.resp_illegal_o), 64'd1);
        chk("ill_result", bus.resp_result_o, 64'd0);
        arch("ill", 64'd100, 12'h010);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.resp_valid_o), 64'd0);
        chk("mid_rst_illegal", 64'(bus.resp_illegal_o), 64'd0);
        chk("mid_rst_ready", 64'(bus.req_ready_o), 64'd1);
        arch("mid_rst", 64'd0, 12'h800);
        @(negedge clk);
        rst_n = 1'b1;
        bus.pipe_idle_i = 1'b1;
        cfg("post_rst", mk_vli(11'h010, 5'd6, 5'd5), 64'd100, 64'd0, 64'd100, 1'b0, 64'd100, 12'h010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vcfg_unit.md
VCFG_UNIT -- requirements
Module: vcfg_unit

Interface
REQ-001 SHALL have parameter VLEN, default 4096, meaning vector register length in bits (power of two, 128..RISCV_MAX_VLEN).
REQ-002 SHALL have parameter ELEN, default 64, meaning maximum supported element width in bits.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk_i  input  1  clock; rst_ni  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports: req_valid_i  input  1  config request valid; req_ready_o  output  1  request accepted when high with valid; req_instr_i  input  32  instruction word; req_rs1_i  input  64  rs1 value; req_rs2_i  input  64  rs2 value.
REQ-005 SHALL have ports: pipe_idle_i  input  1  vector pipeline drained; flush_i  input  1  abort pending request.
REQ-006 SHALL have ports: resp_valid_o  output  1  response valid; resp_ready_i  input  1  response consumed; resp_result_o  output  64  new vl for rd; resp_illegal_o  output  1  illegal instruction.
REQ-007 SHALL have ports: vl_o  output  64  architectural vl; vtype_o  output  12  architectural vtype (vtype_t layout).

Function
REQ-008 SHALL implement FSM IDLE, CALC, RESP; req_ready_o = 1 only in IDLE.
REQ-009 SHALL register instruction, rs1 and rs2 on handshake in IDLE and move to CALC.
REQ-010 SHALL decode when opcode = 7'h57 and func3 = OPCFG: instr[31]=0 -> vsetvli (zimm11); instr[31:30]=11 -> vsetivli (zimm10, AVL = uimm5); instr[31:25]=1000000 -> vsetvl (vtype from rs2[10:0]); any other word -> illegal.
REQ-011 SHALL map requested vtype bits as vlmul=[2:0], vsew=[5:3], vta=[6], vma=[7], vlut=[10:8]; vsetivli vlut[2]=0.
REQ-012 SHALL set vill when vlmul = LMUL_RSVD, SEW > ELEN, vlut > CB256, fractional LMUL with SEW > ELEN*LMUL, or vsetvl rs2[63:11] nonzero.
REQ-013 SHALL compute VLMAX = (VLEN >> (3+vsew)) << vlmul for integer LMUL, >> (8-vlmul) for fractional; vl = min(AVL, VLMAX) without overflow at 64-bit AVL.
REQ-014 SHALL use AVL: rs1 != x0 -> rs1 value; rs1 = x0, rd != x0 -> VLMAX; rs1 = x0, rd = x0 -> min(old vl, VLMAX).
REQ-015 SHALL, when vill, write vtype = {vill=1, others 0} and vl = 0.
REQ-016 SHALL remain in CALC while pipe_idle_i = 0; on pipe_idle_i = 1 SHALL update vl/vtype in the same edge and move to RESP.
REQ-017 SHALL for illegal words leave vl/vtype unchanged, go CALC -> RESP without waiting on pipe_idle_i, and drive resp_illegal_o = 1, resp_result_o = 0.
REQ-018 SHALL drive resp_valid_o = 1 only in RESP, holding result stable until resp_ready_i; handshake returns to IDLE.
REQ-019 SHALL give minimum latency of 2 cycles from request handshake to resp_valid_o.
REQ-020 SHALL on flush_i in CALC return to IDLE with no update and no response; flush_i SHALL be ignored in IDLE and RESP.
REQ-021 SHALL give flush_i priority over pipe_idle_i when both high in CALC.
REQ-022 SHALL drive vl_o/vtype_o from registers; a new value is visible the cycle after the update edge.

Reset
REQ-023 SHALL on rst_ni low force state IDLE, vl = 0, vtype = 12'h800 (vill only), resp_valid_o = 0, resp_result_o = 0, resp_illegal_o = 0, at any time including mid-CALC or mid-RESP, discarding the pending request.

Structure
REQ-024 SHALL take vtype_t, vew_e, vlmul_e, vlut_e, opcodev_func3_e and instruction structs from rvv_pkg; the new vcfg_state_e FSM enum SHALL be added to rvv_pkg.
REQ-025 SHALL place VLMAX computation in one combinational sub-module vcfg_vlmax (inputs vsew, vlmul; output VLMAX).

Verification
REQ-026 vsetvli rd=x5, rs1=x6=100, zimm=0x010 (e32,m1) -> result 100, vl_o=100, vtype_o=12'h010.
REQ-027 vsetvli rd=x1, rs1=x0, zimm=0x003 (e8,m8) -> result 4096, vl_o=4096.
REQ-028 vsetivli uimm5=31, e64, mf8 -> vill: result 0, vl_o=0, vtype_o=12'h800.
REQ-029 vsetvl rs2=0x500 -> vtype_o=12'h500 (CB256) legal; rs2=0x600 -> vtype_o=12'h800.
REQ-030 pipe_idle_i low 5 cycles after request -> resp_valid_o low, vl_o unchanged; flush_i in cycle 3 -> IDLE, no response, vl_o unchanged.
REQ-031 non-config word 32'h0000_0013, then reset asserted in RESP with resp_ready_i=0 -> resp_illegal_o=1 first; after reset resp_valid_o=0, vtype_o=12'h800.
